// File: rtl/clk_phase_pkg.sv
// Shared types and helpers for the MC6809 E/Q quadrature clock generator.
package clk_phase_pkg;

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2,
    PH3 = 2'd3
  } phase_e;

  // Returns {E, Q} for a phase: Q leads E by one quarter.
  function automatic logic [1:0] eq_level(input phase_e ph);
    case (ph)
      PH0:     return 2'b00;
      PH1:     return 2'b01;
      PH2:     return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic phase_e next_phase(input phase_e ph);
    return phase_e'(ph + 2'd1);
  endfunction

  // Bits needed to hold the value max_val.
  function automatic int cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/clk_phase_gen_rst_seq.sv
// Lock synchroniser, release hold-off and CPU reset sequencing for clk_phase_gen.
module rst_seq
  import clk_phase_pkg::*;
#(
  parameter int unsigned RST_HOLD = 16,
  parameter int unsigned RST_ECYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic locked,
  input  logic e_fall,
  output logic released,
  output logic cpu_reset,
  output logic lock_lost
);

  localparam int HW = cnt_w(RST_HOLD);
  localparam int CW = cnt_w(RST_ECYC);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(RST_HOLD);
  localparam logic [CW-1:0] ECYC_LAST = CW'(RST_ECYC - 1);

  logic          lk_meta_q, lk_s_q;
  logic [HW-1:0] hold_q, hold_d;
  logic          rel_q, rel_d;
  logic [CW-1:0] ecyc_q, ecyc_d;
  logic          cpu_reset_q, cpu_reset_d;
  logic          lock_lost_q, lock_lost_d;

  // Lock loss takes effect in the very cycle lk_s drops, not a cycle later.
  assign released  = rel_q & lk_s_q;
  assign cpu_reset = cpu_reset_q;
  assign lock_lost = lock_lost_q;

  always_comb begin
    hold_d = hold_q;
    if (!lk_s_q) begin
      hold_d = '0;
    end else if (hold_q != HOLD_MAX) begin
      hold_d = hold_q + 1'b1;
    end

    rel_d       = lk_s_q & (rel_q | (hold_q == HOLD_MAX));
    lock_lost_d = lock_lost_q | (rel_q & ~lk_s_q);

    ecyc_d      = ecyc_q;
    cpu_reset_d = cpu_reset_q;
    if (!released) begin
      ecyc_d      = '0;
      cpu_reset_d = 1'b1;
    end else if (e_fall && cpu_reset_q) begin
      ecyc_d = ecyc_q + 1'b1;
      if (ecyc_q == ECYC_LAST) begin
        cpu_reset_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lk_meta_q   <= 1'b0;
      lk_s_q      <= 1'b0;
      hold_q      <= '0;
      rel_q       <= 1'b0;
      ecyc_q      <= '0;
      cpu_reset_q <= 1'b1;
      lock_lost_q <= 1'b0;
    end else begin
      lk_meta_q   <= locked;
      lk_s_q      <= lk_meta_q;
      hold_q      <= hold_d;
      rel_q       <= rel_d;
      ecyc_q      <= ecyc_d;
      cpu_reset_q <= cpu_reset_d;
      lock_lost_q <= lock_lost_d;
    end
  end

endmodule

// File: rtl/clk_phase_gen.sv
// MC6809 E/Q quadrature clock and enable generator with lock-based CPU reset.
// Optional E stretching is built only when CLK_STRETCH_EN is defined.
module clk_phase_gen
  import clk_phase_pkg::*;
#(
  parameter int unsigned QDIV        = 4,
  parameter int unsigned RST_HOLD    = 16,
  parameter int unsigned RST_ECYC    = 4,
  parameter int unsigned STRETCH_MAX = 8
) (
  input  logic                             CLK_IN1,
  input  logic                             RESET,
  input  logic                             LOCKED,
`ifdef CLK_STRETCH_EN
  input  logic                             STRETCH,
`endif
  output logic                             E_OUT,
  output logic                             Q_OUT,
  output logic                             E_RISE,
  output logic                             E_FALL,
  output logic                             Q_RISE,
  output logic                             Q_FALL,
  output logic                             CPU_RESET,
  output logic                             LOCK_LOST,
  output phase_e                           dbg_phase,
  output logic [cnt_w(STRETCH_MAX)-1:0]    dbg_scnt
);

  localparam int QW = cnt_w(QDIV - 1);
  localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);

  logic          released;
  logic          tc, hold_ph3;
  phase_e        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic          e_q, q_q;
  logic [1:0]    lvl_d;

`ifdef CLK_STRETCH_EN
  localparam int SW = cnt_w(STRETCH_MAX);
  localparam logic [SW-1:0] SMAX = SW'(STRETCH_MAX);
  logic [SW-1:0] scnt_q, scnt_d;
  assign dbg_scnt = scnt_q;
`else
  assign dbg_scnt = '0;
`endif

  always_comb begin
    tc       = released & (qcnt_q == QLAST);
    hold_ph3 = 1'b0;
`ifdef CLK_STRETCH_EN
    hold_ph3 = (state_q == PH3) & STRETCH & (scnt_q != SMAX);
    scnt_d   = scnt_q;
    if (!released || state_q == PH0) begin
      scnt_d = '0;
    end else if (tc && hold_ph3) begin
      scnt_d = scnt_q + 1'b1;
    end
`endif
    state_d = state_q;
    qcnt_d  = qcnt_q + 1'b1;
    if (!released) begin
      state_d = PH0;
      qcnt_d  = '0;
    end else if (tc) begin
      qcnt_d = '0;
      if (!hold_ph3) begin
        state_d = next_phase(state_q);
      end
    end
    lvl_d = eq_level(state_d);

    // Levels only move at terminal count, so comparing next vs current
    // level yields a single pulse in the cycle before each edge.
    E_RISE = released & lvl_d[1] & ~e_q;
    E_FALL = released & ~lvl_d[1] & e_q;
    Q_RISE = released & lvl_d[0] & ~q_q;
    Q_FALL = released & ~lvl_d[0] & q_q;
  end

  always_ff @(posedge CLK_IN1 or posedge RESET) begin
    if (RESET) begin
      state_q <= PH0;
      qcnt_q  <= '0;
      e_q     <= 1'b0;
      q_q     <= 1'b0;
`ifdef CLK_STRETCH_EN
      scnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      e_q     <= lvl_d[1];
      q_q     <= lvl_d[0];
`ifdef CLK_STRETCH_EN
      scnt_q  <= scnt_d;
`endif
    end
  end

  assign E_OUT     = e_q;
  assign Q_OUT     = q_q;
  assign dbg_phase = state_q;

  rst_seq #(
    .RST_HOLD (RST_HOLD),
    .RST_ECYC (RST_ECYC)
  ) u_rst_seq (
    .clk       (CLK_IN1),
    .rst       (RESET),
    .locked    (LOCKED),
    .e_fall    (E_FALL),
    .released  (released),
    .cpu_reset (CPU_RESET),
    .lock_lost (LOCK_LOST)
  );

endmodule

// File: tb/tb_clk_phase_gen.sv
// Directed bench for clk_phase_gen (QDIV=4, RST_HOLD=16, RST_ECYC=4, STRETCH_MAX=8).
module tb_clk_phase_gen;
  import clk_phase_pkg::*;

  logic clk = 1'b0;
  logic rst, locked;
`ifdef CLK_STRETCH_EN
  logic stretch;
`endif
  logic e_out, q_out, e_rise, e_fall, q_rise, q_fall, cpu_reset, lock_lost;
  phase_e dbg_phase;
  logic [cnt_w(8)-1:0] dbg_scnt;

  int total = 0;
  int bad   = 0;
  int n;

  // Expected-output word layout: {E, Q, ER, EF, QR, QF, CPU_RESET, LOCK_LOST}
  typedef struct {
    int         cyc;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[$];
  string names[8] = '{"E_OUT", "Q_OUT", "E_RISE", "E_FALL",
                      "Q_RISE", "Q_FALL", "CPU_RESET", "LOCK_LOST"};

  always #5 clk = ~clk;

  clk_phase_gen #(
    .QDIV        (4),
    .RST_HOLD    (16),
    .RST_ECYC    (4),
    .STRETCH_MAX (8)
  ) dut (
    .CLK_IN1   (clk),
    .RESET     (rst),
    .LOCKED    (locked),
`ifdef CLK_STRETCH_EN
    .STRETCH   (stretch),
`endif
    .E_OUT     (e_out),
    .Q_OUT     (q_out),
    .E_RISE    (e_rise),
    .E_FALL    (e_fall),
    .Q_RISE    (q_rise),
    .Q_FALL    (q_fall),
    .CPU_RESET (cpu_reset),
    .LOCK_LOST (lock_lost),
    .dbg_phase (dbg_phase),
    .dbg_scnt  (dbg_scnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] exp);
    logic [7:0] cur;
    cur = {e_out, q_out, e_rise, e_fall, q_rise, q_fall, cpu_reset, lock_lost};
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s@%s", names[i], tag), 32'(cur[7-i]), 32'(exp[7-i]));
    end
  endtask

  // One clock edge; n numbers the edge just taken, sampling is at the negedge.
  task automatic tick();
    @(posedge clk);
    n++;
    @(negedge clk);
  endtask

  task automatic advance_to(input int target);
    while (n < target) tick();
  endtask

  // Waits for E_RISE, then counts cycles E_OUT stays high; drops STRETCH at drop_at.
  task automatic measure_e_high(input int drop_at, output int len);
    int guard;
    guard = 0;
    len   = 0;
    while (!e_rise && guard < 64) begin
      tick();
      guard++;
    end
    check("e_rise_seen", 32'(e_rise), 32'd1);
    tick();
    while (e_out && len < 100) begin
      len++;
`ifdef CLK_STRETCH_EN
      if (len == drop_at) stretch = 1'b0;
`else
      if (len == drop_at) len = len + 0;
`endif
      tick();
    end
  endtask

  initial begin
    int len;
    int cnt_er, cnt_ef, cnt_qr, cnt_qf;

    vecs.push_back('{0,   8'b0000_0010});
    vecs.push_back('{17,  8'b0000_0010});
    vecs.push_back('{18,  8'b0000_0010});
    vecs.push_back('{21,  8'b0000_1010});
    vecs.push_back('{22,  8'b0100_0010});
    vecs.push_back('{25,  8'b0110_0010});
    vecs.push_back('{26,  8'b1100_0010});
    vecs.push_back('{29,  8'b1100_0110});
    vecs.push_back('{30,  8'b1000_0010});
    vecs.push_back('{33,  8'b1001_0010});
    vecs.push_back('{34,  8'b0000_0010});
    vecs.push_back('{37,  8'b0000_1010});
    vecs.push_back('{38,  8'b0100_0010});
    vecs.push_back('{41,  8'b0110_0010});
    vecs.push_back('{42,  8'b1100_0010});
    vecs.push_back('{49,  8'b1001_0010});
    vecs.push_back('{50,  8'b0000_0010});
    vecs.push_back('{81,  8'b1001_0010});
    vecs.push_back('{82,  8'b0000_0000});
    vecs.push_back('{98,  8'b0000_0000});
    vecs.push_back('{101, 8'b0000_1000});

    rst    = 1'b1;
    locked = 1'b0;
`ifdef CLK_STRETCH_EN
    stretch = 1'b0;
`endif
    n = 0;
    @(negedge clk);
    @(negedge clk);
    check_outs("reset", 8'b0000_0010);
    check("phase@reset", 32'(dbg_phase), 32'(PH0));
    rst = 1'b0;
    tick();
    tick();

    // Fresh lock: edge 0 is the first edge that samples LOCKED high.
    locked = 1'b1;
    n = -1;
    foreach (vecs[i]) begin
      advance_to(vecs[i].cyc);
      check_outs($sformatf("main%0d", vecs[i].cyc), vecs[i].exp);
      if (vecs[i].cyc == 26) check("phase@26", 32'(dbg_phase), 32'(PH2));
    end

    // Lock loss while E is high.
    advance_to(108);
    check_outs("loss108", 8'b1100_0000);
    locked = 1'b0;
    tick();
    check_outs("loss109", 8'b1100_0100);
    tick();
    check_outs("loss110", 8'b1000_0000);
    tick();
    check_outs("loss111", 8'b0000_0011);

    // Relock repeats the full sequence; LOCK_LOST stays set.
    locked = 1'b1;
    n = -1;
    advance_to(21);
    check_outs("relock21", 8'b0000_1011);
    tick();
    check_outs("relock22", 8'b0100_0011);

    // Asynchronous reset mid-cycle.
    #2 rst = 1'b1;
    #1 check_outs("async_rst", 8'b0000_0010);
    locked = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // LOCKED glitches low 10 cycles into the hold.
    locked = 1'b1;
    n = -1;
    advance_to(10);
    locked = 1'b0;
    advance_to(13);
    locked = 1'b1;
    n = -1;
    advance_to(8);
    check_outs("glitch_norel", 8'b0000_0010);
    advance_to(21);
    check_outs("glitch21", 8'b0000_1010);
    tick();
    check_outs("glitch22", 8'b0100_0010);

    // One pulse of each enable per 16-cycle E period.
    cnt_er = 0; cnt_ef = 0; cnt_qr = 0; cnt_qf = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      cnt_er += int'(e_rise);
      cnt_ef += int'(e_fall);
      cnt_qr += int'(q_rise);
      cnt_qf += int'(q_fall);
    end
    check("e_rise_per_period", 32'(cnt_er), 32'd1);
    check("e_fall_per_period", 32'(cnt_ef), 32'd1);
    check("q_rise_per_period", 32'(cnt_qr), 32'd1);
    check("q_fall_per_period", 32'(cnt_qf), 32'd1);

    measure_e_high(0, len);
    check("e_high_plain", 32'(len), 32'd8);

`ifdef CLK_STRETCH_EN
    stretch = 1'b1;
    measure_e_high(9, len);
    check("e_high_one_stretch", 32'(len), 32'd12);
    stretch = 1'b1;
    measure_e_high(0, len);
    check("e_high_max_stretch", 32'(len), 32'd40);
    stretch = 1'b0;
    measure_e_high(0, len);
    check("e_high_after_stretch", 32'(len), 32'd8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_phase_gen.md
# clk_phase_gen

Parametrised successor to the board clock wrapper: takes the PLL output clock and lock flag and generates the MC6809 quadrature E/Q clocks plus matching single-cycle enables for CLK_IN1-domain logic. Also sequences the CPU reset from PLL lock, and supports MRDY-style E stretching. Sits between the PLL instance and the mc6809 core and bus logic on every devboard top.

## Interface
- QDIV, 4: CLK_IN1 cycles per quarter E period; legal ≥2; E period = 4*QDIV nominal
- RST_HOLD, 16: consecutive cycles synced LOCKED must stay high before the generator is released
- RST_ECYC, 4: full E cycles CPU_RESET stays high after release
- STRETCH_MAX, 8: max consecutive extra quarters per E cycle
- CLK_IN1  in  1  PLL output clock; only clock
- RESET  in  1  asynchronous, active-high reset
- LOCKED  in  1  PLL lock, asynchronous to CLK_IN1
- STRETCH  in  1  request to extend E high (present only with CLK_STRETCH_EN)
- E_OUT, Q_OUT  out  1  registered level clocks
- E_RISE, E_FALL, Q_RISE, Q_FALL  out  1  one-cycle enables, high in the cycle before the matching edge of E_OUT/Q_OUT
- CPU_RESET  out  1  CPU-domain reset, deasserts synchronously
- LOCK_LOST  out  1  sticky: lock dropped after release

## Operation
- LOCKED passes a 2-flop synchroniser (lk_s); all logic uses lk_s.
- Hold counter counts lk_s-high cycles; release when it reaches RST_HOLD; lk_s low clears it.
- Phase FSM, 4 states, each QDIV cycles (qcnt 0..QDIV-1): PH0 (E=0,Q=0) → PH1 (E=0,Q=1) → PH2 (E=1,Q=1) → PH3 (E=1,Q=0) → PH0.
- Not released: FSM forced to PH0, qcnt=0, all outputs 0 except CPU_RESET=1.
- Edge enables derived from terminal count (qcnt==QDIV-1) and next state; exactly one pulse per edge, none while held.
- CPU_RESET: ECYC counter increments on each E_FALL after release; CPU_RESET drops on the same edge E_OUT falls for the RST_ECYC-th time.
- Lock loss after release: lk_s low → same cycle FSM returns to PH0, E/Q low, enables 0, CPU_RESET=1, LOCK_LOST=1, hold and ECYC counters cleared; relock repeats full sequence. LOCK_LOST cleared only by RESET.
- Lock loss before release: counter restart only, LOCK_LOST unchanged.

## Timing
- Reset values: E_OUT=Q_OUT=0, all enables 0, CPU_RESET=1, LOCK_LOST=0, FSM PH0, counters 0.
- LOCKED sampled high at edge t → lk_s high at t+2 → release at t+2+RST_HOLD → Q_OUT rises at release+QDIV.
- Edge spacing QDIV cycles; E high 2*QDIV cycles unstretched.
- STRETCH sampled only at PH3 terminal count.
- RESET asserted mid-cycle: outputs to reset values asynchronously; no partial-phase recovery.

## Configuration
- CLK_STRETCH_EN defined: STRETCH port exists; STRETCH high at PH3 terminal count repeats PH3 (E high, Q low, qcnt reloaded) for one more quarter; stretch counter caps at STRETCH_MAX, then PH3→PH0 regardless; counter clears in PH0.
- Undefined: no STRETCH port, no stretch counter; PH3 always advances after QDIV cycles.

## Structure
- Package clk_phase_pkg: phase enum (PH0..PH3), E/Q level decode function per phase, counter-width helper ($clog2-based) for qcnt, hold, stretch, ECYC counters.
- Sub-module rst_seq: LOCKED synchroniser, hold counter, release flag, ECYC counter, CPU_RESET/LOCK_LOST; phase FSM and enables stay in top.

## Test plan
- QDIV=4, RST_HOLD=16: LOCKED high from reset release → Q_OUT first rises 22 cycles after LOCKED sampled; E period 16, Q leads E by 4 cycles.
- Enables: each *_RISE/*_FALL exactly one cycle, one cycle before its level edge; 4 pulses per 16-cycle E period.
- RST_ECYC=4: CPU_RESET falls on same edge as 4th E_OUT fall after release; stays 0 thereafter.
- LOCKED glitches low 10 cycles into hold → no release; release occurs RST_HOLD cycles after lk_s re-rises; LOCK_LOST stays 0.
- LOCKED drops while E_OUT=1 after release → within 2 cycles of synchroniser: E/Q 0, CPU_RESET 1, LOCK_LOST 1; relock restarts full sequence, LOCK_LOST still 1 until RESET.
- CLK_STRETCH_EN, STRETCH held high: E high 8+8*4=40 cycles (STRETCH_MAX=8) then falls; STRETCH one quarter only → E high 12 cycles.
